// File: rtl/dividend_reconstructor_pipelined.sv
// Pipelined signed recomposer: Num = Coc*Den + Res, one operation per cycle,
// latency etapas+2, sign-magnitude shift-add with a final signed add of Res.
module dividend_reconstructor_pipelined #(
    parameter int unsigned tamanyo = 32,
    parameter int unsigned etapas  = 32
) (
    input  logic               CLK,
    input  logic               RSTa,
    input  logic               Start,
    input  logic [tamanyo-1:0] Coc,
    input  logic [tamanyo-1:0] Den,
    input  logic [tamanyo-1:0] Res,
    output logic [tamanyo-1:0] Num,
    output logic               Overflow,
    output logic               Done
);

    localparam int unsigned w  = tamanyo;
    localparam int unsigned kb = tamanyo / etapas;
    localparam int unsigned dw = 2 * tamanyo;

    function automatic logic [w-1:0] mag(input logic [w-1:0] x);
        return x[w-1] ? w'(-x) : x;
    endfunction

    // Per-stage state; index 0 is the input register, index etapas the last adder.
    logic          vld_q [etapas+1];
    logic          neg_q [etapas+1];
    logic [dw-1:0] acc_q [etapas+1];
    logic [dw-1:0] res_q [etapas+1];
    logic [w-1:0]  mpl_q [etapas];
    logic [dw-1:0] mcd_q [etapas];

    // Sign/negation stage between the adders and the final Res addition
    logic          p_vld_q;
    logic [dw-1:0] p_q;
    logic [dw-1:0] p_res_q;
    logic [dw:0]   f_c;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            vld_q[0] <= 1'b0;
            neg_q[0] <= 1'b0;
            acc_q[0] <= '0;
            res_q[0] <= '0;
            mpl_q[0] <= '0;
            mcd_q[0] <= '0;
        end else begin
            vld_q[0] <= Start;
            if (Start) begin
                neg_q[0] <= Coc[w-1] ^ Den[w-1];
                acc_q[0] <= '0;
                res_q[0] <= {{w{Res[w-1]}}, Res};
                mpl_q[0] <= mag(Coc);
                mcd_q[0] <= dw'(mag(Den));
            end
        end
    end

    for (genvar i = 1; i <= etapas; i++) begin : g_stage
        logic [dw-1:0] sum_c;
        logic [w-1:0]  m_c;
        logic [dw-1:0] mc_c;

        // Add the multiplicand, shifted per bit, for each of this stage's multiplier bits
        always_comb begin
            sum_c = acc_q[i-1];
            m_c   = mpl_q[i-1];
            mc_c  = mcd_q[i-1];
            for (int unsigned j = 0; j < kb; j++) begin
                if (m_c[0]) begin
                    sum_c = sum_c + mc_c;
                end
                m_c  = m_c >> 1;
                mc_c = mc_c << 1;
            end
        end

        always_ff @(posedge CLK or negedge RSTa) begin
            if (!RSTa) begin
                vld_q[i] <= 1'b0;
                neg_q[i] <= 1'b0;
                acc_q[i] <= '0;
                res_q[i] <= '0;
            end else begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    neg_q[i] <= neg_q[i-1];
                    acc_q[i] <= sum_c;
                    res_q[i] <= res_q[i-1];
                end
            end
        end

        if (i < etapas) begin : g_shift
            always_ff @(posedge CLK or negedge RSTa) begin
                if (!RSTa) begin
                    mpl_q[i] <= '0;
                    mcd_q[i] <= '0;
                end else if (vld_q[i-1]) begin
                    mpl_q[i] <= mpl_q[i-1] >> kb;
                    mcd_q[i] <= mcd_q[i-1] << kb;
                end
            end
        end
    end

    always_comb begin
        f_c = {p_q[dw-1], p_q} + {p_res_q[dw-1], p_res_q};
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            p_vld_q  <= 1'b0;
            p_q      <= '0;
            p_res_q  <= '0;
            Num      <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
        end else begin
            p_vld_q <= vld_q[etapas];
            if (vld_q[etapas]) begin
                p_q     <= neg_q[etapas] ? dw'(-acc_q[etapas]) : acc_q[etapas];
                p_res_q <= res_q[etapas];
            end
            Done <= p_vld_q;
            if (p_vld_q) begin
                Num      <= f_c[w-1:0];
                // Representable only if every bit from the result sign upward agrees
                Overflow <= !((&f_c[dw:w-1]) || !(|f_c[dw:w-1]));
            end
        end
    end

endmodule

// File: tb/tb_dividend_reconstructor_pipelined.sv
// Directed and random checks of dividend_reconstructor_pipelined at its default
// configuration (latency 34).
module tb_dividend_reconstructor_pipelined;

    localparam int unsigned LAT = 34;

    logic        CLK = 1'b0;
    logic        RSTa;
    logic        Start;
    logic [31:0] Coc, Den, Res;
    logic [31:0] Num;
    logic        Overflow;
    logic        Done;

    int ntests = 0;
    int nfail  = 0;

    typedef struct {
        logic [31:0] coc;
        logic [31:0] den;
        logic [31:0] res;
        logic [31:0] num;
        logic        ovf;
    } vec_t;

    vec_t vecs [13];

    dividend_reconstructor_pipelined dut (
        .CLK      (CLK),
        .RSTa     (RSTa),
        .Start    (Start),
        .Coc      (Coc),
        .Den      (Den),
        .Res      (Res),
        .Num      (Num),
        .Overflow (Overflow),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Independent reference: 64-bit signed arithmetic
    task automatic model(input logic [31:0] c, input logic [31:0] d, input logic [31:0] r,
                         output logic [31:0] n, output logic o);
        longint f;
        f = longint'($signed(c)) * longint'($signed(d)) + longint'($signed(r));
        n = f[31:0];
        o = (f[63:31] != {33{f[31]}});
    endtask

    task automatic run_one(input vec_t v, input string name);
        int lat;
        logic [31:0] held;
        lat = 0;
        @(negedge CLK);
        Start = 1'b1; Coc = v.coc; Den = v.den; Res = v.res;
        @(posedge CLK); #1;
        Start = 1'b0; Coc = $urandom; Den = $urandom; Res = $urandom;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!Done && lat < 60);
        check({name, " latency"}, 32'(lat), 32'(LAT));
        check({name, " num"}, Num, v.num);
        check({name, " ovf"}, 32'(Overflow), 32'(v.ovf));
        held = Num;
        @(posedge CLK); #1;
        check({name, " done pulse"}, 32'(Done), 32'd0);
        check({name, " num hold"}, Num, held);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] pick [5];
        int unsigned mode;
        pick[0] = 32'h8000_0000; pick[1] = 32'h7FFF_FFFF; pick[2] = 32'h0;
        pick[3] = 32'h1;         pick[4] = 32'hFFFF_FFFF;
        mode = $urandom_range(0, 3);
        if (mode == 0) return pick[$urandom_range(0, 4)];
        if (mode == 1) return 32'($urandom_range(0, 200)) - 32'd100;
        return $urandom;
    endfunction

    initial begin
        logic [31:0] b2b_num [40];
        logic        b2b_done [40];
        logic [31:0] q_num [$];
        logic        q_ovf [$];
        logic [31:0] en;
        logic        eo;
        int          seen;

        vecs[0]  = '{32'd7,          32'd3,          32'd1,          32'd22,         1'b0};
        vecs[1]  = '{-32'sd7,        32'd3,          -32'sd1,        32'hFFFF_FFEA,  1'b0};
        vecs[2]  = '{-32'sd7,        -32'sd3,        32'd1,          32'd22,         1'b0};
        vecs[3]  = '{32'd7,          -32'sd3,        32'd1,          32'hFFFF_FFEC,  1'b0};
        vecs[4]  = '{32'h4000_0000,  32'd2,          32'd0,          32'h8000_0000,  1'b1};
        vecs[5]  = '{32'h8000_0000,  32'd1,          32'd0,          32'h8000_0000,  1'b0};
        vecs[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b1};
        vecs[7]  = '{32'h7FFF_FFFF,  32'd1,          32'd1,          32'h8000_0000,  1'b1};
        vecs[8]  = '{32'd5,          32'd0,          -32'sd9,        32'hFFFF_FFF7,  1'b0};
        vecs[9]  = '{32'd0,          32'hFFFF_FFFF,  32'd0,          32'd0,          1'b0};
        vecs[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h7FFF_FFFF,  32'h8000_0000,  1'b1};
        vecs[11] = '{32'h8000_0000,  32'h8000_0000,  32'd0,          32'd0,          1'b1};
        vecs[12] = '{32'hFFFF_FFFF,  32'd1,          32'h8000_0000,  32'h7FFF_FFFF,  1'b1};

        RSTa = 1'b0; Start = 1'b0; Coc = '0; Den = '0; Res = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset num", Num, 32'd0);
        check("reset ovf", 32'(Overflow), 32'd0);
        check("reset done", 32'(Done), 32'd0);
        @(negedge CLK); RSTa = 1'b1;

        for (int i = 0; i < 13; i++) run_one(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back: 4 ops, one bubble, one op
        for (int c = 0; c < 40; c++) begin
            b2b_done[c] = 1'b0; b2b_num[c] = '0;
        end
        b2b_done[LAT]   = 1'b1; b2b_num[LAT]   = 32'd1;
        b2b_done[LAT+1] = 1'b1; b2b_num[LAT+1] = 32'd7;
        b2b_done[LAT+2] = 1'b1; b2b_num[LAT+2] = 32'hFFFF_FFE9;
        b2b_done[LAT+3] = 1'b1; b2b_num[LAT+3] = 32'd10007;
        b2b_done[LAT+5] = 1'b1; b2b_num[LAT+5] = 32'd81;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            Start = 1'b1;
            case (c)
                0: begin Coc = 32'd1;   Den = 32'd1;   Res = 32'd0;   end
                1: begin Coc = 32'd2;   Den = 32'd3;   Res = 32'd1;   end
                2: begin Coc = -32'sd5; Den = 32'd4;   Res = -32'sd3; end
                3: begin Coc = 32'd100; Den = 32'd100; Res = 32'd7;   end
                5: begin Coc = 32'd9;   Den = 32'd9;   Res = 32'd0;   end
                default: begin Start = 1'b0; Coc = $urandom; Den = $urandom; Res = $urandom; end
            endcase
            @(posedge CLK); #1;
            if (c >= LAT - 1) begin
                check($sformatf("b2b done c%0d", c), 32'(Done), 32'(b2b_done[c]));
                if (b2b_done[c]) check($sformatf("b2b num c%0d", c), Num, b2b_num[c]);
            end
        end
        Start = 1'b0;

        // Reset while three operations are in flight
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            Start = (c < 3); Coc = 32'd11; Den = 32'd13; Res = 32'd5;
        end
        @(negedge CLK); Start = 1'b0; RSTa = 1'b0;
        #1;
        check("midreset num", Num, 32'd0);
        check("midreset ovf", 32'(Overflow), 32'd0);
        repeat (2) @(negedge CLK);
        RSTa = 1'b1;
        seen = 0;
        repeat (50) begin
            @(posedge CLK); #1;
            if (Done) seen++;
        end
        check("midreset no done", 32'(seen), 32'd0);
        run_one(vecs[0], "post reset");

        // Random stream with scoreboard
        for (int c = 0; c < 300 + LAT + 6; c++) begin
            @(negedge CLK);
            if (c < 300 && $urandom_range(0, 3) != 0) begin
                Start = 1'b1; Coc = rnd_op(); Den = rnd_op(); Res = rnd_op();
                model(Coc, Den, Res, en, eo);
                q_num.push_back(en);
                q_ovf.push_back(eo);
            end else begin
                Start = 1'b0;
            end
            @(posedge CLK); #1;
            if (Done) begin
                if (q_num.size() == 0) begin
                    check("rand spurious done", 32'(Done), 32'd0);
                end else begin
                    en = q_num.pop_front();
                    eo = q_ovf.pop_front();
                    check($sformatf("rand num c%0d", c), Num, en);
                    check($sformatf("rand ovf c%0d", c), 32'(Overflow), 32'(eo));
                end
            end
        end
        Start = 1'b0;
        check("rand all retired", 32'(q_num.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/dividend_reconstructor_pipelined.md
Name: dividend_reconstructor_pipelined

Overview:
- Fully pipelined signed recomposer for the divider path: from a quotient, divisor and remainder it computes Num = Coc*Den + Res.
- Runs the divider's operation in the other direction. It sits after the segmented divider as an on-line result checker, or standalone as a pipelined signed multiply-accumulate.
- Accepts one operation per cycle. Latency is fixed.

Parameters:
- tamanyo, 32, operand/result width in bits (two's complement).
- etapas, 32, number of shift-add stages. Must divide tamanyo. Each stage consumes tamanyo/etapas multiplier bits.

Ports:
- CLK  in  1  clock, rising edge.
- RSTa  in  1  asynchronous, active-low reset.
- Start  in  1  operands valid this cycle; one operation per asserted cycle.
- Coc  in  tamanyo  signed quotient (multiplier).
- Den  in  tamanyo  signed divisor (multiplicand).
- Res  in  tamanyo  signed remainder (addend).
- Num  out  tamanyo  low tamanyo bits of Coc*Den+Res.
- Overflow  out  1  full-precision result not representable in tamanyo signed bits.
- Done  out  1  one-cycle pulse; Num/Overflow valid this cycle.

Behaviour:
- Reset (RSTa low, async):
  - All stage valid bits, accumulators, operand registers and outputs go to 0: Num=0, Overflow=0, Done=0.
  - In-flight operations are discarded; no Done is produced for them after release.
- Input stage (cycle 0, Start=1 at the clock edge):
  - Register sign bits sC=Coc[msb], sD=Den[msb].
  - Register magnitudes |Coc|, |Den| as tamanyo-bit unsigned values. The most negative input maps to 2^(tamanyo-1), which fits.
  - Register Res sign-extended to 2*tamanyo bits.
  - Clear the 2*tamanyo-bit accumulator.
  - A valid bit travels with every stage; stages with valid=0 hold their contents, but their output is ignored.
- Shift-add stages 1..etapas:
  - Each stage examines k=tamanyo/etapas bits of |Coc|, LSB-first.
  - For each set bit j it adds |Den|<<j into the accumulator. The stage bit offset is carried as a shifted multiplicand register.
  - Accumulation is unsigned on 2*tamanyo bits; no overflow is possible.
- Output stage (stage etapas+1):
  - P = (sC^sD) ? -acc : acc, on 2*tamanyo bits.
  - F = P + Res_ext, on 2*tamanyo+1 bits.
  - Num <= F[tamanyo-1:0].
  - Overflow <= 1 unless F[2*tamanyo:tamanyo-1] are all equal.
  - Done <= 1.
- Latency: Start sampled at edge n gives Done=1 at edge n+etapas+2. The default configuration therefore has latency 34.
- Throughput: Start may be high every cycle. The Done pattern reproduces the Start pattern delayed by the latency, results in order, with no bubbles inserted.
- Done low: Num and Overflow hold their last value.
- Boundary cases:
  - Den=0 or Coc=0: Num=Res, Overflow=0.
  - Coc=-2^(tamanyo-1), Den=-1: Overflow=1.
  - Res alone can push a valid product out of range; Overflow is then 1.
  - Inputs need not be held after the Start cycle.
- No backpressure: the downstream consumer must accept every Done.

Test Plan:
- Basic (defaults): Coc=7, Den=3, Res=1, single Start -> Num=22 (0x16), Overflow=0, Done exactly one cycle, 34 edges after Start.
- Signs: Coc=-7, Den=3, Res=-1 -> Num=0xFFFFFFEA (-22). Coc=-7, Den=-3, Res=1 -> Num=22. Coc=7, Den=-3, Res=1 -> Num=-20. Overflow=0 in all cases.
- Back-to-back: Start high 4 consecutive cycles with (1,1,0), (2,3,1), (-5,4,-3), (100,100,7), then one idle cycle, then (9,9,0) -> Done high 4 cycles with Num = 1, 7, -23, 10007, low 1 cycle, high with 81.
- Overflow boundaries:
  - 0x40000000*2+0 -> Num=0x80000000, Overflow=1.
  - 0x80000000*1+0 -> Num=0x80000000, Overflow=0.
  - 0x80000000*(-1)+0 -> Overflow=1.
  - 0x7FFFFFFF*1+1 -> Num=0x80000000, Overflow=1.
- Zero operands: Coc=5, Den=0, Res=-9 -> Num=0xFFFFFFF7, Overflow=0. Coc=0, Den=-1, Res=0 -> Num=0.
- Reset mid-flight: 3 Starts, RSTa low for 2 cycles at 10 cycles after the first -> Num=0, Overflow=0 immediately, no Done ever appears. A new Start after release -> correct result at nominal latency.
- Parameter sweep: tamanyo=32, etapas=8 and etapas=1 -> latency 10 and 3 respectively; 10k random signed vectors compared against a reference model.
